// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide scheduler and HI/LO register owner.
//   clk, reset       : clock and synchronous active-high reset
//   start, op, a, b  : E-stage MD op request and its forwarded operands
//   md_use_D         : D-stage instruction touches HI/LO or the MD unit
//   busy             : registered, high while an operation is in flight
//   stall_md         : combinational stall request for the D-stage pause logic
//   hi, lo           : committed HI/LO registers
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d;

  // Result datapath, evaluated from latched operands only
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_zero, div_ovf;
  logic signed [31:0] div_den_s;
  logic        [31:0] div_den_u;
  logic signed [31:0] quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;

  always_comb begin
    prod_s    = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u    = {32'd0, a_q} * {32'd0, b_q};
    div_zero  = (b_q == 32'd0);
    div_ovf   = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    // Sanitised divisors keep the dividers away from undefined corner cases
    div_den_s = (div_zero || div_ovf) ? 32'sd1 : $signed(b_q);
    div_den_u = div_zero ? 32'd1 : b_q;
    quo_s     = $signed(a_q) / div_den_s;
    rem_s     = $signed(a_q) % div_den_s;
    quo_u     = a_q / div_den_u;
    rem_u     = a_q % div_den_u;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_d    = op[1:0];
              a_d     = a;
              b_d     = b;
              cnt_d   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              state_d = RUN;
              busy_d  = 1'b1;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end

      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          case (op_q)
            2'd0: {hi_d, lo_d} = prod_s;
            2'd1: {hi_d, lo_d} = prod_u;
            2'd2: begin
              if (div_ovf) begin
                lo_d = 32'h8000_0000;
                hi_d = 32'd0;
              end else if (!div_zero) begin
                lo_d = quo_s;
                hi_d = rem_s;
              end
            end
            default: begin
              if (!div_zero) begin
                lo_d = quo_u;
                hi_d = rem_u;
              end
            end
          endcase
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  // Stall covers both an MD op sitting in E and one already running
  assign stall_md = md_use_D & (start | busy_q);
  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
